// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with flush, sticky halt, occupancy and stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a fully registered in_ready.
module pipe_stage_reg #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_halt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_halt,
   output logic          halted,
   output logic [1:0]    occupancy,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stageState_t;

   stageState_t   stateReg, stateNext;
   logic [DW-1:0] mainDataReg;
   logic          mainHaltReg;
   logic          haltedReg;
   logic [CW-1:0] stallReg;
   logic          accept, pop, loadMainIn;
`ifdef PIPE_STAGE_SKID_EN
   logic [DW-1:0] skidDataReg;
   logic          skidHaltReg;
   logic          loadMainSkid, loadSkid;
`endif

   assign out_valid = (stateReg != EMPTY);
   assign out_data  = out_valid ? mainDataReg : '0;
   assign out_halt  = out_valid & mainHaltReg;
   assign halted    = haltedReg;
   assign occupancy = stateReg;
   assign stall_cnt = stallReg;

`ifdef PIPE_STAGE_SKID_EN
   assign in_ready = (stateReg != TWO) && !haltedReg;
`else
   assign in_ready = (!out_valid || out_ready) && !haltedReg;
`endif

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_comb begin
      stateNext  = stateReg;
      loadMainIn = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
`endif
      case (stateReg)
         EMPTY: begin
            if (accept) begin
               stateNext  = ONE;
               loadMainIn = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               loadMainIn = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            end else if (accept) begin
               stateNext = TWO;
               loadSkid  = 1'b1;
`endif
            end else if (pop) begin
               stateNext = EMPTY;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         TWO: begin
            if (pop) begin
               stateNext    = ONE;
               loadMainSkid = 1'b1;
            end
         end
`endif
         default: stateNext = EMPTY;
      endcase
      // Flush wins: an accept in the same cycle is consumed upstream but dropped here.
      if (flush) begin
         stateNext  = EMPTY;
         loadMainIn = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
         loadMainSkid = 1'b0;
         loadSkid     = 1'b0;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stateReg  <= EMPTY;
         haltedReg <= 1'b0;
         stallReg  <= '0;
      end else begin
         stateReg <= stateNext;
         if (flush)
            haltedReg <= 1'b0;
         else if (accept && in_halt)
            haltedReg <= 1'b1;
         // Saturating count; flush deliberately leaves it alone.
         if (out_valid && !out_ready && (stallReg != {CW{1'b1}}))
            stallReg <= stallReg + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mainDataReg <= '0;
         mainHaltReg <= 1'b0;
      end else if (loadMainIn) begin
         mainDataReg <= in_data;
         mainHaltReg <= in_halt;
`ifdef PIPE_STAGE_SKID_EN
      end else if (loadMainSkid) begin
         mainDataReg <= skidDataReg;
         mainHaltReg <= skidHaltReg;
`endif
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         skidDataReg <= '0;
         skidHaltReg <= 1'b0;
      end else if (loadSkid) begin
         skidDataReg <= in_data;
         skidHaltReg <= in_halt;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; works for both the default and PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;
   localparam int DW  = 8;
   localparam int CW  = 16;
   localparam int CWS = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_halt = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;

   logic           in_ready, out_valid, out_halt, halted;
   logic [DW-1:0]  out_data;
   logic [1:0]     occupancy;
   logic [CW-1:0]  stall_cnt;

   logic           sInReady, sOutValid, sOutHalt, sHalted;
   logic [DW-1:0]  sOutData;
   logic [1:0]     sOccupancy;
   logic [CWS-1:0] sStallCnt;

   int compared = 0;
   int mismatched = 0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.DW(DW), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
      .halted(halted), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   // Narrow-counter copy sharing the same stimulus, used for saturation checks.
   pipe_stage_reg #(.DW(DW), .CW(CWS)) dutSat (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(sInReady), .in_data(in_data), .in_halt(in_halt),
      .out_valid(sOutValid), .out_ready(out_ready), .out_data(sOutData), .out_halt(sOutHalt),
      .halted(sHalted), .occupancy(sOccupancy), .stall_cnt(sStallCnt)
   );

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_halt = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      compared++; if (out_data !== 8'h00) begin mismatched++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      compared++; if (out_halt !== 1'b0) begin mismatched++; $display("FAIL rst_out_halt got=%b exp=0", out_halt); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL rst_halted got=%b exp=0", halted); end
      compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      $display("reset: out_valid=%b occupancy=%0d in_ready=%b", out_valid, occupancy, in_ready);
   endtask

   task automatic test_stream();
      logic [DW-1:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         out_ready = 1'b1;
         in_valid  = (i < 3);
         in_data   = (i < 3) ? vals[i] : 8'h00;
         #1;
         if (i < 3) begin
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
         end
         if (i > 0) begin
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_out_valid[%0d] got=%b exp=1", i, out_valid); end
            compared++; if (out_data !== vals[i-1]) begin mismatched++; $display("FAIL stream_out_data[%0d] got=%h exp=%h", i, out_data, vals[i-1]); end
            $display("stream: out_data=%h", out_data);
         end else begin
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_first_empty got=%b exp=0", out_valid); end
         end
      end
      @(negedge CLK); in_valid = 1'b0; #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
`ifdef PIPE_STAGE_SKID_EN
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0; #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL skid_in_ready_a got=%b exp=1", in_ready); end
      @(negedge CLK); in_data = 8'h0B; #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL skid_in_ready_b got=%b exp=1", in_ready); end
      compared++; if (out_data !== 8'h0A) begin mismatched++; $display("FAIL skid_head_a got=%h exp=0a", out_data); end
      @(negedge CLK); in_data = 8'h0C; #1;
      compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL skid_occupancy got=%0d exp=2", occupancy); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL skid_full_in_ready got=%b exp=0", in_ready); end
      @(negedge CLK); out_ready = 1'b1; #1;
      compared++; if (out_data !== 8'h0A) begin mismatched++; $display("FAIL skid_pop_a got=%h exp=0a", out_data); end
      compared++; if (stall_cnt !== 16'd2) begin mismatched++; $display("FAIL skid_stall_cnt got=%0d exp=2", stall_cnt); end
      @(negedge CLK); #1;
      compared++; if (out_data !== 8'h0B) begin mismatched++; $display("FAIL skid_pop_b got=%h exp=0b", out_data); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL skid_reopen got=%b exp=1", in_ready); end
      @(negedge CLK); in_valid = 1'b0; #1;
      compared++; if (out_data !== 8'h0C) begin mismatched++; $display("FAIL skid_pop_c got=%h exp=0c", out_data); end
      @(negedge CLK); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL skid_drained got=%b exp=0", out_valid); end
      compared++; if (stall_cnt !== 16'd2) begin mismatched++; $display("FAIL skid_stall_final got=%0d exp=2", stall_cnt); end
      $display("skid: drained, stall_cnt=%0d", stall_cnt);
`else
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0; #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_in_ready_a got=%b exp=1", in_ready); end
      @(negedge CLK); in_data = 8'h0B; #1;
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_blocked got=%b exp=0", in_ready); end
      compared++; if (occupancy !== 2'd1) begin mismatched++; $display("FAIL bp_occupancy got=%0d exp=1", occupancy); end
      @(negedge CLK); out_ready = 1'b1; #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_comb_ready got=%b exp=1", in_ready); end
      compared++; if (out_data !== 8'h0A) begin mismatched++; $display("FAIL bp_pop_a got=%h exp=0a", out_data); end
      compared++; if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL bp_stall_cnt got=%0d exp=1", stall_cnt); end
      @(negedge CLK); in_valid = 1'b0; #1;
      compared++; if (out_data !== 8'h0B) begin mismatched++; $display("FAIL bp_pop_b got=%h exp=0b", out_data); end
      @(negedge CLK); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
      $display("backpressure: drained, stall_cnt=%0d", stall_cnt);
`endif
   endtask

   task automatic test_halt();
      do_reset();
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h05; in_halt = 1'b1; out_ready = 1'b0; #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL halt_pre_ready got=%b exp=1", in_ready); end
      @(negedge CLK); in_data = 8'h06; in_halt = 1'b0; out_ready = 1'b1; #1;
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_set got=%b exp=1", halted); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL halt_in_ready got=%b exp=0", in_ready); end
      compared++; if (out_data !== 8'h05) begin mismatched++; $display("FAIL halt_out_data got=%h exp=05", out_data); end
      compared++; if (out_halt !== 1'b1) begin mismatched++; $display("FAIL halt_out_halt got=%b exp=1", out_halt); end
      @(negedge CLK); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL halt_drained got=%b exp=0", out_valid); end
      compared++; if (out_halt !== 1'b0) begin mismatched++; $display("FAIL halt_out_halt_idle got=%b exp=0", out_halt); end
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_sticky got=%b exp=1", halted); end
      @(negedge CLK); flush = 1'b1; #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL halt_no_intake got=%b exp=0", out_valid); end
      @(negedge CLK); flush = 1'b0; in_valid = 1'b0; #1;
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL halt_flush_clear got=%b exp=0", halted); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL halt_flush_ready got=%b exp=1", in_ready); end
      $display("halt: cleared by flush, halted=%b", halted);
   endtask

   task automatic test_flush();
      do_reset();
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h41; in_halt = 1'b0; out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      @(negedge CLK); in_data = 8'h42; in_halt = 1'b1;
`endif
      @(negedge CLK); in_data = 8'h77; in_halt = 1'b1; flush = 1'b1; out_ready = 1'b1; #1;
      compared++; if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin mismatched++; $display("FAIL flush_pre_occ got=%0d exp=%0d", occupancy, SKID ? 2 : 1); end
      compared++; if (halted !== SKID) begin mismatched++; $display("FAIL flush_pre_halted got=%b exp=%b", halted, SKID); end
      compared++; if (out_data !== 8'h41) begin mismatched++; $display("FAIL flush_pre_data got=%h exp=41", out_data); end
      @(negedge CLK); flush = 1'b0; in_valid = 1'b0; in_halt = 1'b0; #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      compared++; if (out_data !== 8'h00) begin mismatched++; $display("FAIL flush_out_data got=%h exp=00", out_data); end
      compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL flush_halted got=%b exp=0", halted); end
      @(negedge CLK); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_discard got=%b data=%h exp=0", out_valid, out_data); end
      $display("flush: occupancy=%0d out_valid=%b", occupancy, out_valid);
   endtask

   task automatic test_saturate();
      do_reset();
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
      @(negedge CLK); in_valid = 1'b0;
      repeat (20) @(negedge CLK);
      #1;
      compared++; if (sStallCnt !== 4'd15) begin mismatched++; $display("FAIL sat_cw4 got=%0d exp=15", sStallCnt); end
      compared++; if (stall_cnt !== 16'd20) begin mismatched++; $display("FAIL sat_cw16 got=%0d exp=20", stall_cnt); end
      flush = 1'b1;
      @(negedge CLK); flush = 1'b0; #1;
      compared++; if (sStallCnt !== 4'd15) begin mismatched++; $display("FAIL sat_after_flush got=%0d exp=15", sStallCnt); end
      compared++; if (stall_cnt !== 16'd21) begin mismatched++; $display("FAIL sat_cw16_flush got=%0d exp=21", stall_cnt); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL sat_flushed got=%b exp=0", out_valid); end
      RST = 1'b1;
      @(negedge CLK); RST = 1'b0; #1;
      compared++; if (sStallCnt !== 4'd0) begin mismatched++; $display("FAIL sat_rst got=%0d exp=0", sStallCnt); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL sat_rst16 got=%0d exp=0", stall_cnt); end
      $display("saturate: cw4 stall_cnt=%0d after reset", sStallCnt);
   endtask

   task automatic test_rst_flush();
      do_reset();
      @(negedge CLK); in_valid = 1'b1; in_data = 8'h3C; in_halt = 1'b1; out_ready = 1'b0;
      @(negedge CLK); in_valid = 1'b0; in_halt = 1'b0; RST = 1'b1; flush = 1'b1; #1;
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL rf_pre_halted got=%b exp=1", halted); end
      @(negedge CLK); RST = 1'b0; flush = 1'b0; #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rf_out_valid got=%b exp=0", out_valid); end
      compared++; if (out_data !== 8'h00) begin mismatched++; $display("FAIL rf_out_data got=%h exp=00", out_data); end
      compared++; if (out_halt !== 1'b0) begin mismatched++; $display("FAIL rf_out_halt got=%b exp=0", out_halt); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL rf_halted got=%b exp=0", halted); end
      compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL rf_occupancy got=%0d exp=0", occupancy); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL rf_stall_cnt got=%0d exp=0", stall_cnt); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rf_in_ready got=%b exp=1", in_ready); end
      $display("rst_flush: occupancy=%0d halted=%b", occupancy, halted);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_halt();
      test_flush();
      test_saturate();
      test_rst_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached compared=%0d", compared);
      $fatal(1, "watchdog");
   end

endmodule
